fifo_control: RTL

- Pointer and flag controller that sequences the single-port-pair FIFO storage array.
- Converts requester push/pop into memory write/read enables and addresses, and tracks occupancy.
- Produces full/empty/almost-full/almost-empty flags for upstream flow control and a read-valid strobe aligned to the array's registered read data.
- Sits between the transaction-layer producer/consumer and the storage array; one instance per FIFO.

---
 rtl/fifo_control_pkg.sv | 6 +
 rtl/fifo_ptr_wrap.sv | 34 +++
 rtl/fifo_control.sv | 92 +++++++++
 3 files changed

// File: rtl/fifo_control_pkg.sv
// rtl/fifo_control_pkg.sv - shared depth and width constants for the FIFO controller
package fifo_control_pkg;
    localparam int FIFO_MEM_DEPTH = 8;
    localparam int FIFO_PTR_SIZE  = $clog2(FIFO_MEM_DEPTH);
    localparam int FIFO_CNT_SIZE  = FIFO_PTR_SIZE + 1;
endpackage

// File: rtl/fifo_ptr_wrap.sv
// rtl/fifo_ptr_wrap.sv - wrapping address pointer register for a DEPTH-word array
module fifo_ptr_wrap #(
    parameter int DEPTH = 8,
    parameter int W     = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] ptr
);
    localparam logic [W-1:0] LAST = W'(DEPTH - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    // Explicit wrap so non-power-of-two depths never index past the array
    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
endmodule

// File: rtl/fifo_control.sv
// rtl/fifo_control.sv - FIFO pointer/flag controller; FIFO_CTRL_STICKY_ERR_EN makes error flags sticky
module fifo_control
    import fifo_control_pkg::*;
#(
    parameter int MEM_DEPTH = FIFO_MEM_DEPTH,
    parameter int PTR_SIZE  = $clog2(MEM_DEPTH),
    parameter int CNT_SIZE  = PTR_SIZE + 1
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                push,
    input  logic                pop,
    input  logic [CNT_SIZE-1:0] thr_almost_full,
    input  logic [CNT_SIZE-1:0] thr_almost_empty,
    output logic                wr_en,
    output logic                rd_en,
    output logic [PTR_SIZE-1:0] wr_ptr,
    output logic [PTR_SIZE-1:0] rd_ptr,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [CNT_SIZE-1:0] fifo_count,
    output logic                data_valid,
    output logic                overflow_err,
    output logic                underflow_err
);
    localparam logic [CNT_SIZE-1:0] DEPTH_C = CNT_SIZE'(MEM_DEPTH);

    logic [CNT_SIZE-1:0] cnt_q, cnt_d;
    logic full_q, empty_q, afull_q, aempty_q;
    logic dvalid_q, ovf_q, udf_q;
    logic ovf_d, udf_d;

    // Push while full is still accepted when a pop frees the slot in the same cycle
    assign rd_en = reset_L & pop & ~empty_q;
    assign wr_en = reset_L & push & (~full_q | pop);

    assign cnt_d = cnt_q + CNT_SIZE'(wr_en) - CNT_SIZE'(rd_en);
    assign ovf_d = push & full_q & ~pop;
    assign udf_d = pop & empty_q;

    fifo_ptr_wrap #(.DEPTH(MEM_DEPTH), .W(PTR_SIZE)) u_wr_ptr (
        .clk   (clk),
        .rst_n (reset_L),
        .en    (wr_en),
        .ptr   (wr_ptr)
    );

    fifo_ptr_wrap #(.DEPTH(MEM_DEPTH), .W(PTR_SIZE)) u_rd_ptr (
        .clk   (clk),
        .rst_n (reset_L),
        .en    (rd_en),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            dvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            full_q   <= (cnt_d == DEPTH_C);
            empty_q  <= (cnt_d == '0);
            afull_q  <= (cnt_d >= thr_almost_full);
            aempty_q <= (cnt_d <= thr_almost_empty);
            dvalid_q <= rd_en;
`ifdef FIFO_CTRL_STICKY_ERR_EN
            ovf_q    <= ovf_q | ovf_d;
            udf_q    <= udf_q | udf_d;
`else
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
`endif
        end
    end

    assign fifo_count    = cnt_q;
    assign full          = full_q;
    assign empty         = empty_q;
    assign almost_full   = afull_q;
    assign almost_empty  = aempty_q;
    assign data_valid    = dvalid_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = udf_q;
endmodule
